// File: rtl/example_packet_checker.sv
// rtl/example_packet_checker.sv - Receive-side checker for looped-back example test packets
//
// Purpose:
//   Watches a 32-bit AXI-Stream receive path with no backpressure and checks
//   every packet against the test-packet generator format:
//     data[15:0]  = beat index (0..length)
//     data[31:16] = fixed pattern
//     tlast       = on the beat whose index equals the packet length
//   Statistics counters saturate at all-ones and are intended for VIO/ILA readout.
//
// Ports:
//   i_clk, i_reset_n       stream clock, asynchronous active-low reset
//   i_clear                synchronous clear of counters and alignment
//   i_packet_length        expected index of the last beat (latched per packet)
//   i_pattern              expected data[31:16] (latched per packet)
//   s00_axis_*             receive stream (tdata/tkeep/tvalid/tlast/tuser)
//   o_aligned              high once the first packet boundary has been seen
//   o_good_count           packets passing all checks
//   o_bad_count            packets failing any check
//   o_crc_error_count      packets ending with tuser=1
//   o_seq_error_count      beats with index/pattern/keep/tlast mismatch
//   o_error_pulse          one-cycle pulse when a bad packet completes
//   o_first_error_index    received index of first failing beat of the last bad packet

module example_packet_checker #(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_clear,
    input  logic [15:0]            i_packet_length,
    input  logic [15:0]            i_pattern,
    input  logic [31:0]            s00_axis_tdata,
    input  logic [3:0]             s00_axis_tkeep,
    input  logic                   s00_axis_tvalid,
    input  logic                   s00_axis_tlast,
    input  logic                   s00_axis_tuser,
    output logic                   o_aligned,
    output logic [COUNT_WIDTH-1:0] o_good_count,
    output logic [COUNT_WIDTH-1:0] o_bad_count,
    output logic [COUNT_WIDTH-1:0] o_crc_error_count,
    output logic [COUNT_WIDTH-1:0] o_seq_error_count,
    output logic                   o_error_pulse,
    output logic [15:0]            o_first_error_index
);

    typedef enum logic [1:0] {
        S_ALIGN = 2'd0,
        S_START = 2'd1,
        S_BODY  = 2'd2
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    state_t state_q, state_d;

    logic [15:0]            len_q;
    logic [15:0]            pat_q;
    logic [15:0]            exp_idx_q;
    logic                   pkt_bad_q;
    logic [COUNT_WIDTH-1:0] good_q;
    logic [COUNT_WIDTH-1:0] bad_q;
    logic [COUNT_WIDTH-1:0] crc_q;
    logic [COUNT_WIDTH-1:0] seq_q;
    logic                   pulse_q;
    logic [15:0]            first_err_q;

    logic [15:0] beat_idx;
    logic [15:0] beat_pat;
    logic [15:0] cur_len;
    logic [15:0] cur_pat;
    logic [15:0] cur_exp;
    logic        chk_beat;
    logic        pkt_done;
    logic        beat_fail;
    logic        pkt_bad;

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    assign beat_idx = s00_axis_tdata[15:0];
    assign beat_pat = s00_axis_tdata[31:16];

    // On the first beat of a packet the working registers are being loaded
    // this very cycle, so compare against the live inputs instead.
    assign cur_len = (state_q == S_START) ? i_packet_length : len_q;
    assign cur_pat = (state_q == S_START) ? i_pattern       : pat_q;
    assign cur_exp = (state_q == S_START) ? 16'd0           : exp_idx_q;

    assign chk_beat = s00_axis_tvalid && (state_q != S_ALIGN);
    assign pkt_done = chk_beat && s00_axis_tlast;

    assign beat_fail = (beat_idx != cur_exp)
                     | (beat_pat != cur_pat)
                     | (s00_axis_tkeep != 4'hF)
                     | (s00_axis_tlast ? (beat_idx != cur_len) : (beat_idx == cur_len));

    assign pkt_bad = pkt_bad_q | beat_fail | s00_axis_tuser;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_ALIGN;
        end else if (i_clear) begin
            state_q <= S_ALIGN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ALIGN: if (s00_axis_tvalid && s00_axis_tlast) state_d = S_START;
            S_START: if (s00_axis_tvalid) state_d = s00_axis_tlast ? S_START : S_BODY;
            S_BODY:  if (s00_axis_tvalid && s00_axis_tlast) state_d = S_START;
            default: state_d = S_ALIGN;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            len_q       <= '0;
            pat_q       <= '0;
            exp_idx_q   <= '0;
            pkt_bad_q   <= 1'b0;
            good_q      <= '0;
            bad_q       <= '0;
            crc_q       <= '0;
            seq_q       <= '0;
            pulse_q     <= 1'b0;
            first_err_q <= '0;
        end else if (i_clear) begin
            len_q       <= '0;
            pat_q       <= '0;
            exp_idx_q   <= '0;
            pkt_bad_q   <= 1'b0;
            good_q      <= '0;
            bad_q       <= '0;
            crc_q       <= '0;
            seq_q       <= '0;
            pulse_q     <= 1'b0;
            first_err_q <= '0;
        end else begin
            pulse_q <= pkt_done && pkt_bad;
            if (s00_axis_tvalid && state_q == S_START) begin
                len_q <= i_packet_length;
                pat_q <= i_pattern;
            end
            if (chk_beat) begin
                // Resynchronise on what was received so one bad index costs one error.
                exp_idx_q <= beat_idx + 16'd1;
                if (beat_fail) begin
                    seq_q <= sat_inc(seq_q);
                    if (!pkt_bad_q) first_err_q <= beat_idx;
                end
                pkt_bad_q <= s00_axis_tlast ? 1'b0 : (pkt_bad_q | beat_fail);
            end
            if (pkt_done) begin
                if (s00_axis_tuser) crc_q <= sat_inc(crc_q);
                if (pkt_bad) bad_q  <= sat_inc(bad_q);
                else         good_q <= sat_inc(good_q);
            end
        end
    end

    assign o_aligned           = (state_q != S_ALIGN);
    assign o_good_count        = good_q;
    assign o_bad_count         = bad_q;
    assign o_crc_error_count   = crc_q;
    assign o_seq_error_count   = seq_q;
    assign o_error_pulse       = pulse_q;
    assign o_first_error_index = first_err_q;

endmodule

// File: tb/tb_example_packet_checker.sv
// tb/tb_example_packet_checker.sv - Self-checking bench for example_packet_checker

module tb_example_packet_checker;

    localparam logic [15:0] P  = 16'hA5A5;
    localparam logic [3:0]  KF = 4'hF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic [15:0] plen;
    logic [15:0] pat;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tvalid;
    logic        tlast;
    logic        tuser;

    logic        aligned, pulse;
    logic [31:0] good, bad, crc, seq;
    logic [15:0] fei;

    logic        aligned2, pulse2;
    logic [2:0]  good2, bad2, crc2, seq2;
    logic [15:0] fei2;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    example_packet_checker #(.COUNT_WIDTH(32)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_clear(clr),
        .i_packet_length(plen), .i_pattern(pat),
        .s00_axis_tdata(tdata), .s00_axis_tkeep(tkeep), .s00_axis_tvalid(tvalid),
        .s00_axis_tlast(tlast), .s00_axis_tuser(tuser),
        .o_aligned(aligned), .o_good_count(good), .o_bad_count(bad),
        .o_crc_error_count(crc), .o_seq_error_count(seq),
        .o_error_pulse(pulse), .o_first_error_index(fei)
    );

    example_packet_checker #(.COUNT_WIDTH(3)) dut_small (
        .i_clk(clk), .i_reset_n(rst_n), .i_clear(clr),
        .i_packet_length(plen), .i_pattern(pat),
        .s00_axis_tdata(tdata), .s00_axis_tkeep(tkeep), .s00_axis_tvalid(tvalid),
        .s00_axis_tlast(tlast), .s00_axis_tuser(tuser),
        .o_aligned(aligned2), .o_good_count(good2), .o_bad_count(bad2),
        .o_crc_error_count(crc2), .o_seq_error_count(seq2),
        .o_error_pulse(pulse2), .o_first_error_index(fei2)
    );

    typedef struct {
        logic        v;
        logic [15:0] idx;
        logic [15:0] hi;
        logic        last;
        logic        user;
        logic [3:0]  keep;
        logic [15:0] len;
        logic        al;
        int          g, b, c, s;
        logic        p;
        logic [15:0] fei;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic v, logic [15:0] idx, logic [15:0] hi, logic last,
                                logic user, logic [3:0] keep, logic [15:0] len,
                                logic al, int g, int b, int c, int s, logic p,
                                logic [15:0] f);
        vec_t t;
        t.v = v; t.idx = idx; t.hi = hi; t.last = last; t.user = user; t.keep = keep;
        t.len = len; t.al = al; t.g = g; t.b = b; t.c = c; t.s = s; t.p = p; t.fei = f;
        vecs.push_back(t);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] idx, input logic [15:0] hi,
                         input logic last, input logic user, input logic [3:0] keep,
                         input logic [15:0] len);
        tvalid = v; tdata = {hi, idx}; tlast = last; tuser = user; tkeep = keep; plen = len;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string nm, input logic al, input int g, input int b,
                           input int c, input int s, input logic p, input logic [15:0] f);
        chk({nm, " aligned"}, {31'd0, aligned}, {31'd0, al});
        chk({nm, " good"}, good, g);
        chk({nm, " bad"}, bad, b);
        chk({nm, " crc"}, crc, c);
        chk({nm, " seq"}, seq, s);
        chk({nm, " pulse"}, {31'd0, pulse}, {31'd0, p});
        chk({nm, " first_err"}, {16'd0, fei}, {16'd0, f});
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; plen = 16'd3; pat = P;
        tdata = '0; tkeep = KF; tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;

        // align on preamble, then three good packets
        add(1,2,P,1,0,KF,3, 1,0,0,0,0,0,0);
        for (int k = 0; k < 3; k++) begin
            add(1,0,P,0,0,KF,3, 1,k,0,0,0,0,0);
            add(1,1,P,0,0,KF,3, 1,k,0,0,0,0,0);
            add(1,2,P,0,0,KF,3, 1,k,0,0,0,0,0);
            add(1,3,P,1,0,KF,3, 1,k+1,0,0,0,0,0);
        end
        // idx 1 replaced by 7: 7 fails, then 2 fails against resynced expectation 8
        add(1,0,P,0,0,KF,3, 1,3,0,0,0,0,0);
        add(1,7,P,0,0,KF,3, 1,3,0,0,1,0,7);
        add(1,2,P,0,0,KF,3, 1,3,0,0,2,0,7);
        add(1,3,P,1,0,KF,3, 1,3,1,0,2,1,7);
        // good packet, pulse drops
        add(1,0,P,0,0,KF,3, 1,3,1,0,2,0,7);
        add(1,1,P,0,0,KF,3, 1,3,1,0,2,0,7);
        add(1,2,P,0,0,KF,3, 1,3,1,0,2,0,7);
        add(1,3,P,1,0,KF,3, 1,4,1,0,2,0,7);
        // CRC error on otherwise correct packet
        add(1,0,P,0,0,KF,3, 1,4,1,0,2,0,7);
        add(1,1,P,0,0,KF,3, 1,4,1,0,2,0,7);
        add(1,2,P,0,0,KF,3, 1,4,1,0,2,0,7);
        add(1,3,P,1,1,KF,3, 1,4,2,1,2,1,7);
        // wrong pattern on beat 1, partial tkeep on beat 2
        add(1,0,P,0,0,KF,3, 1,4,2,1,2,0,7);
        add(1,1,16'h0000,0,0,KF,3, 1,4,2,1,3,0,1);
        add(1,2,P,0,0,4'h7,3, 1,4,2,1,4,0,1);
        add(1,3,P,1,0,KF,3, 1,4,3,1,4,1,1);
        // early tlast at idx 1
        add(1,0,P,0,0,KF,3, 1,4,3,1,4,0,1);
        add(1,1,P,1,0,KF,3, 1,4,4,1,5,1,1);
        add(1,0,P,0,0,KF,3, 1,4,4,1,5,0,1);
        add(1,1,P,0,0,KF,3, 1,4,4,1,5,0,1);
        add(1,2,P,0,0,KF,3, 1,4,4,1,5,0,1);
        add(1,3,P,1,0,KF,3, 1,5,4,1,5,0,1);
        // missing tlast at idx 3, tlast at idx 4
        add(1,0,P,0,0,KF,3, 1,5,4,1,5,0,1);
        add(1,1,P,0,0,KF,3, 1,5,4,1,5,0,1);
        add(1,2,P,0,0,KF,3, 1,5,4,1,5,0,1);
        add(1,3,P,0,0,KF,3, 1,5,4,1,6,0,3);
        add(1,4,P,1,0,KF,3, 1,5,5,1,7,1,3);
        // invalid beat carrying tlast/tuser is ignored
        add(0,9,P,1,1,KF,3, 1,5,5,1,7,0,3);
        // length 0 single-beat packets with gaps
        add(1,0,P,1,0,KF,0, 1,6,5,1,7,0,3);
        add(0,0,P,1,1,KF,0, 1,6,5,1,7,0,3);
        add(1,0,P,1,0,KF,0, 1,7,5,1,7,0,3);
        add(0,0,P,0,0,KF,0, 1,7,5,1,7,0,3);
        add(1,0,P,1,0,KF,0, 1,8,5,1,7,0,3);
        // length input changes mid-packet have no effect
        add(1,0,P,0,0,KF,3, 1,8,5,1,7,0,3);
        add(1,1,P,0,0,KF,0, 1,8,5,1,7,0,3);
        add(1,2,P,0,0,KF,0, 1,8,5,1,7,0,3);
        add(1,3,P,1,0,KF,0, 1,9,5,1,7,0,3);

        @(posedge clk); @(posedge clk); #1;
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        drive(1,5,P,0,0,KF,3);
        chk_all("align discard", 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].v, vecs[i].idx, vecs[i].hi, vecs[i].last, vecs[i].user,
                  vecs[i].keep, vecs[i].len);
            chk_all($sformatf("vec%0d", i), vecs[i].al, vecs[i].g, vecs[i].b,
                    vecs[i].c, vecs[i].s, vecs[i].p, vecs[i].fei);
        end

        // narrow counters saturate instead of wrapping
        chk("sat good", {29'd0, good2}, 32'd7);
        chk("sat seq", {29'd0, seq2}, 32'd7);
        chk("sat bad", {29'd0, bad2}, 32'd5);

        // asynchronous reset mid-packet
        drive(1,0,P,0,0,KF,3);
        drive(1,1,P,0,0,KF,3);
        rst_n = 1'b0;
        #2;
        chk_all("async rst", 0, 0, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b1;
        drive(1,2,P,0,0,KF,3);
        chk_all("rst discard", 0, 0, 0, 0, 0, 0, 0);
        drive(1,3,P,1,0,KF,3);
        chk_all("rst realign", 1, 0, 0, 0, 0, 0, 0);
        drive(1,0,P,0,0,KF,3);
        drive(1,1,P,0,0,KF,3);
        drive(1,2,P,0,0,KF,3);
        drive(1,3,P,1,0,KF,3);
        chk_all("rst good pkt", 1, 1, 0, 0, 0, 0, 0);

        // clear coincident with tlast of a bad packet
        drive(1,0,P,0,0,KF,3);
        drive(1,1,16'h1234,0,0,KF,3);
        chk_all("pre clear", 1, 1, 0, 0, 1, 0, 1);
        drive(1,2,P,0,0,KF,3);
        clr = 1'b1;
        drive(1,3,P,1,1,KF,3);
        clr = 1'b0;
        chk_all("clear", 0, 0, 0, 0, 0, 0, 0);
        drive(1,0,P,0,0,KF,3);
        chk_all("clr discard", 0, 0, 0, 0, 0, 0, 0);
        drive(1,1,P,1,0,KF,3);
        chk_all("clr realign", 1, 0, 0, 0, 0, 0, 0);
        drive(1,0,P,0,0,KF,3);
        drive(1,1,P,0,0,KF,3);
        drive(1,2,P,0,0,KF,3);
        drive(1,3,P,1,0,KF,3);
        chk_all("clr good pkt", 1, 1, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
